temp_sensor_filter: RTL

- Upstream stage of the greenhouse temperature controller.
- Takes raw signed 8-bit greenhouse and outside temperature samples, each qualified by a strobe.
- Smooths each channel with a power-of-two sliding-window average.
- Drives the controller's greenhouse_temp input, plus the temp_g_greenhouse_temp flag (outside warmer than greenhouse, with hysteresis).

---
 rtl/temp_sensor_filter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/temp_sensor_filter.sv
// Two-channel sliding-window temperature filter with a hysteretic outside-warmer flag.
// Optional range check / sticky sensor fault is built when TEMP_RANGE_CHECK_EN is defined.
module temp_sensor_filter #(
  parameter int LOG2_N    = 2,
  parameter int HYST      = 1,
  parameter int TEMP_MIN  = -40,
  parameter int TEMP_MAX  = 125,
  parameter int FAULT_CNT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic signed [7:0] gh_sample,
  input  logic signed [7:0] out_sample,
  output logic signed [7:0] greenhouse_temp,
  output logic              temp_g_greenhouse_temp,
  output logic              temp_valid,
  output logic              sensor_fault
);

  localparam int N  = 1 << LOG2_N;
  localparam int SW = 8 + LOG2_N;
  localparam int PW = (LOG2_N > 0) ? LOG2_N : 1;

  typedef enum logic {StEmpty, StRun} state_e;

  state_e                 state_q, state_d;
  logic signed [7:0]      gh_buf_q  [N];
  logic signed [7:0]      out_buf_q [N];
  logic signed [SW-1:0]   gh_sum_q, gh_sum_d;
  logic signed [SW-1:0]   out_sum_q, out_sum_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   upd_q;
  logic signed [7:0]      gh_temp_q;
  logic                   flag_q, flag_d;
  logic                   valid_q;
  logic                   accept;
  logic signed [7:0]      gh_avg, out_avg;
  logic signed [9:0]      gh10, out10, hyst10;

`ifdef TEMP_RANGE_CHECK_EN
  localparam int CW = $clog2(FAULT_CNT + 1);

  logic          in_range;
  logic [CW-1:0] rej_cnt_q, rej_cnt_d;
  logic          fault_q;

  assign in_range = (32'(gh_sample) >= TEMP_MIN) && (32'(gh_sample) <= TEMP_MAX) &&
                    (32'(out_sample) >= TEMP_MIN) && (32'(out_sample) <= TEMP_MAX);
  assign accept   = sample_valid & in_range;

  // Saturating count of consecutive rejected strobes.
  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (accept) begin
      rej_cnt_d = '0;
    end else if (sample_valid && (rej_cnt_q != CW'(FAULT_CNT))) begin
      rej_cnt_d = rej_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      rej_cnt_q <= rej_cnt_d;
      fault_q   <= fault_q | (rej_cnt_q == CW'(FAULT_CNT));
    end
  end

  assign sensor_fault = fault_q;
`else
  logic unused_cfg;

  assign accept       = sample_valid;
  assign sensor_fault = 1'b0;
  assign unused_cfg   = ^{32'(TEMP_MIN), 32'(TEMP_MAX), 32'(FAULT_CNT)};
`endif

  // Stage 1: window state update on an accepted strobe.
  always_comb begin
    state_d   = state_q;
    gh_sum_d  = gh_sum_q;
    out_sum_d = out_sum_q;
    ptr_d     = ptr_q;
    if (accept) begin
      unique case (state_q)
        StEmpty: begin
          gh_sum_d  = SW'(gh_sample) <<< LOG2_N;
          out_sum_d = SW'(out_sample) <<< LOG2_N;
          ptr_d     = '0;
          state_d   = StRun;
        end
        StRun: begin
          gh_sum_d  = gh_sum_q - SW'(gh_buf_q[ptr_q]) + SW'(gh_sample);
          out_sum_d = out_sum_q - SW'(out_buf_q[ptr_q]) + SW'(out_sample);
          ptr_d     = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + PW'(1);
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      gh_sum_q  <= '0;
      out_sum_q <= '0;
      ptr_q     <= '0;
      upd_q     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        gh_buf_q[i]  <= '0;
        out_buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      gh_sum_q  <= gh_sum_d;
      out_sum_q <= out_sum_d;
      ptr_q     <= ptr_d;
      upd_q     <= accept;
      if (accept) begin
        if (state_q == StEmpty) begin
          for (int i = 0; i < N; i++) begin
            gh_buf_q[i]  <= gh_sample;
            out_buf_q[i] <= out_sample;
          end
        end else begin
          gh_buf_q[ptr_q]  <= gh_sample;
          out_buf_q[ptr_q] <= out_sample;
        end
      end
    end
  end

  // Stage 2: averages and hysteretic compare on the freshly updated sums.
  always_comb begin
    gh_avg  = 8'(gh_sum_q >>> LOG2_N);
    out_avg = 8'(out_sum_q >>> LOG2_N);
    gh10    = 10'(gh_avg);
    out10   = 10'(out_avg);
    hyst10  = 10'(HYST);
    flag_d  = flag_q;
    if (flag_q) begin
      if (out10 < gh10 - hyst10) flag_d = 1'b0;
    end else begin
      if (out10 > gh10 + hyst10) flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gh_temp_q <= '0;
      flag_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else if (upd_q) begin
      gh_temp_q <= gh_avg;
      flag_q    <= flag_d;
      valid_q   <= 1'b1;
    end
  end

  assign greenhouse_temp        = gh_temp_q;
  assign temp_g_greenhouse_temp = flag_q;
  assign temp_valid             = valid_q;

endmodule
